// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: scan states,
// segment bit positions and the BCD decode table.
package seg_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_GUARD = 2'd2
    } scan_state_t;

    // Segment vector is {a,b,c,d,e,f,g}; bit positions within it
    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    // All segments dark
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Decode table, 1 = segment lit
    localparam logic [6:0] SEG_DIGIT_0 = 7'b1111110;
    localparam logic [6:0] SEG_DIGIT_1 = 7'b0110000;
    localparam logic [6:0] SEG_DIGIT_2 = 7'b1101101;
    localparam logic [6:0] SEG_DIGIT_3 = 7'b1111001;
    localparam logic [6:0] SEG_DIGIT_4 = 7'b0110011;
    localparam logic [6:0] SEG_DIGIT_5 = 7'b1011011;
    localparam logic [6:0] SEG_DIGIT_6 = 7'b1011111;
    localparam logic [6:0] SEG_DIGIT_7 = 7'b1110000;
    localparam logic [6:0] SEG_DIGIT_8 = 7'b1111111;
    localparam logic [6:0] SEG_DIGIT_9 = 7'b1111011;

endpackage

// File: rtl/seg_display_scanner_decode.sv
// Combinational BCD nibble to {a,b,c,d,e,f,g} decoder; codes 10..15 are dark.
module bcd_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup; anything outside 0..9 is a blank digit
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_DIGIT_0;
            4'd1:    seg = SEG_DIGIT_1;
            4'd2:    seg = SEG_DIGIT_2;
            4'd3:    seg = SEG_DIGIT_3;
            4'd4:    seg = SEG_DIGIT_4;
            4'd5:    seg = SEG_DIGIT_5;
            4'd6:    seg = SEG_DIGIT_6;
            4'd7:    seg = SEG_DIGIT_7;
            4'd8:    seg = SEG_DIGIT_8;
            4'd9:    seg = SEG_DIGIT_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed 7-segment scan controller. A BCD word is taken over a
// valid/ready handshake, held in a pending buffer while scanning, and swapped
// into the displayed buffer only at a frame boundary so a frame never tears.
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int GUARD_CYC   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_bcd,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = (GUARD_CYC > 0) ? CNT_W'(GUARD_CYC - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    scan_state_t           state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [IDX_W-1:0]      idx_wrap;
    logic [4*DIGITS-1:0]   disp_reg, disp_next;
    logic [4*DIGITS-1:0]   pend_reg, pend_next;
    logic                  pend_v_reg, pend_v_next;
    logic                  ready_reg, ready_next;
    logic [6:0]            seg_reg, seg_next;
    logic [DIGITS-1:0]     an_reg, an_next;

    logic                  accept;
    logic                  frame_end;
    logic [3:0]            disp_nib [DIGITS];
    logic [DIGITS:0]       lz_chain;
    logic [DIGITS-1:0]     an_hot;
    logic [3:0]            cur_nib;
    logic [6:0]            dec_seg;
    logic                  blank_digit;

    assign accept   = load_valid && ready_reg;
    assign idx_wrap = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);

    // Per-digit views of the next displayed word, leading-zero chain and
    // one-hot enable for the next digit index. lz_chain[k] is set when digit k
    // and every more significant digit are zero.
    assign lz_chain[DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign disp_nib[gi] = disp_next[4*gi +: 4];
            assign lz_chain[gi] = lz_chain[gi+1] && (disp_nib[gi] == 4'd0);
            assign an_hot[gi]   = (idx_next == IDX_W'(gi));
        end
    endgenerate

    // Outputs are registered alongside state, so decode works on next-state values
    assign cur_nib     = disp_nib[idx_next];
    assign blank_digit = blank_lz && (idx_next != '0) && lz_chain[idx_next];

    bcd_seg_decode u_decode (
        .bcd (cur_nib),
        .seg (dec_seg)
    );

    // Next-state logic: scan sequencing, buffer management and output values
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + CNT_W'(1);
        idx_next    = idx_reg;
        disp_next   = disp_reg;
        pend_next   = pend_reg;
        pend_v_next = pend_v_reg;
        frame_end   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                // First word bypasses pending and is shown immediately
                if (accept) begin
                    disp_next  = load_bcd;
                    state_next = ST_SHOW;
                    idx_next   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_reg == SHOW_LAST) begin
                    cnt_next = '0;
                    if (GUARD_CYC == 0) begin
                        idx_next  = idx_wrap;
                        frame_end = (idx_reg == IDX_LAST);
                    end else begin
                        state_next = ST_GUARD;
                    end
                end
            end
            ST_GUARD: begin
                if (cnt_reg == GUARD_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_SHOW;
                    idx_next   = idx_wrap;
                    frame_end  = (idx_reg == IDX_LAST);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase

        if (state_reg != ST_IDLE) begin
            // Swap in the pending word only as the scan returns to digit 0
            if (frame_end && pend_v_reg) begin
                disp_next   = pend_reg;
                pend_v_next = 1'b0;
            end
            // Accept only happens with pending empty, so no clash with the swap
            if (accept) begin
                pend_next   = load_bcd;
                pend_v_next = 1'b1;
            end
        end

        ready_next = !pend_v_next;

        seg_next = SEG_BLANK;
        an_next  = '0;
        if (state_next == ST_SHOW) begin
            an_next  = an_hot;
            seg_next = blank_digit ? SEG_BLANK : dec_seg;
        end
    end

    // State, buffers and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            disp_reg   <= '0;
            pend_reg   <= '0;
            pend_v_reg <= 1'b0;
            ready_reg  <= 1'b1;
            seg_reg    <= SEG_BLANK;
            an_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            disp_reg   <= disp_next;
            pend_reg   <= pend_next;
            pend_v_reg <= pend_v_next;
            ready_reg  <= ready_next;
            seg_reg    <= seg_next;
            an_reg     <= an_next;
        end
    end

    assign load_ready = ready_reg;
    assign seg        = seg_reg;
    assign an         = an_reg;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner (DIGITS=4, REFRESH_DIV=4,
// GUARD_CYC=1). Expected an/seg/load_ready values are queued with the cycle
// they must appear in and compared by a monitor on the falling edge.
module tb_seg_display_scanner;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;
    localparam int GUARD_CYC   = 1;
    localparam int SLOT        = REFRESH_DIV + GUARD_CYC;
    localparam int FRAME       = DIGITS * SLOT;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                load_valid = 1'b0;
    logic                load_ready;
    logic [4*DIGITS-1:0] load_bcd = '0;
    logic                blank_lz = 1'b0;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    typedef struct {
        int                cyc;
        logic [DIGITS-1:0] an;
        logic [6:0]        seg;
        logic              rdy;
        string             tag;
    } exp_t;

    exp_t sb_q[$];

    logic [6:0] seg_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011};

    seg_display_scanner #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD_CYC   (GUARD_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_bcd   (load_bcd),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected segments for digit k of a word, leading-zero blanking included
    function automatic logic [6:0] exp_seg(input logic [4*DIGITS-1:0] word, input int k, input logic lz);
        logic [3:0]          nib;
        logic [4*DIGITS-1:0] upper;
        nib   = word[4*k +: 4];
        upper = word >> (4*k);
        if (lz && k > 0 && upper == '0) return 7'b0000000;
        if (nib > 4'd9) return 7'b0000000;
        return seg_tbl[nib];
    endfunction

    task automatic push(input int c, input logic [DIGITS-1:0] a, input logic [6:0] s,
                        input logic r, input string tag);
        exp_t e;
        e.cyc = c; e.an = a; e.seg = s; e.rdy = r; e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Queue one frame (or its first len cycles); load_ready is low from offset rdy_low_from on
    task automatic push_frame(input int start, input logic [4*DIGITS-1:0] word, input logic lz,
                              input int rdy_low_from, input int len);
        for (int off = 0; off < len; off++) begin
            int d;
            int p;
            logic r;
            d = off / SLOT;
            p = off % SLOT;
            r = (off < rdy_low_from);
            if (p < REFRESH_DIV)
                push(start + off, DIGITS'(1) << d, exp_seg(word, d, lz), r,
                     $sformatf("w%h_show%0d_c%0d", word, d, start + off));
            else
                push(start + off, '0, 7'b0000000, r,
                     $sformatf("w%h_guard%0d_c%0d", word, d, start + off));
        end
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every queued expectation in its cycle
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.cyc < cyc) begin
                check_eq({e.tag, "_missed"}, 32'(cyc), 32'(e.cyc));
            end else begin
                check_eq({e.tag, "_an"},  32'(an),         32'(e.an));
                check_eq({e.tag, "_seg"}, 32'(seg),        32'(e.seg));
                check_eq({e.tag, "_rdy"}, 32'(load_ready), 32'(e.rdy));
            end
        end
    end

    initial begin
        // Reset for two edges, then idle with no load
        for (int c = 1; c <= 8; c++) push(c, '0, 7'b0000000, 1'b1, $sformatf("idle_c%0d", c));
        goto_cyc(2);
        rst = 1'b0;

        // 1234 loaded in IDLE; 5678 arrives during SHOW(1) and waits for the frame end
        goto_cyc(8);
        load_valid = 1'b1; load_bcd = 16'h1234;
        push_frame(9, 16'h1234, 1'b0, 6, FRAME);
        goto_cyc(9);
        load_valid = 1'b0;
        goto_cyc(14);
        load_valid = 1'b1; load_bcd = 16'h5678;
        push_frame(29, 16'h5678, 1'b0, 1, FRAME);
        goto_cyc(15);
        load_valid = 1'b0;

        // 0070 with leading-zero blanking, then the same word without it
        goto_cyc(29);
        blank_lz = 1'b1; load_valid = 1'b1; load_bcd = 16'h0070;
        push_frame(49, 16'h0070, 1'b1, FRAME, FRAME);
        goto_cyc(30);
        load_valid = 1'b0;
        goto_cyc(68);
        blank_lz = 1'b0;
        push_frame(69, 16'h0070, 1'b0, 1, FRAME);

        // 00A5, then valid held with 9999 while the buffer is full
        goto_cyc(69);
        load_valid = 1'b1; load_bcd = 16'h00A5;
        push_frame(89, 16'h00A5, 1'b0, 1, 3*SLOT);
        goto_cyc(70);
        load_bcd = 16'h9999;
        goto_cyc(90);
        load_valid = 1'b0;

        // Reset during GUARD(2) with 9999 pending: scan aborts, word is dropped
        goto_cyc(103);
        rst = 1'b1;
        for (int c = 104; c <= 112; c++) push(c, '0, 7'b0000000, 1'b1, $sformatf("rst_idle_c%0d", c));
        goto_cyc(105);
        rst = 1'b0;
        goto_cyc(113);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
